// File: rtl/axi_monitor_pkg.sv
// Shared types and report-word layout for the AXI-Stream handshake monitor.
package axi_monitor_pkg;

  // Report state machine: waiting for a sample trigger, or streaming a burst.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Channel index width in the report word (up to 16 channels).
  localparam int CH_ID_W = 4;

  // Report word field positions.
  localparam int WORD_W      = 32;
  localparam int CH_MSB      = 31;
  localparam int CH_LSB      = 28;
  localparam int SAT_BIT     = 27;
  localparam int CNT_FIELD_W = 24;

  // Assemble one report word; bits [26:24] stay zero.
  function automatic logic [WORD_W-1:0] make_word(input logic [CH_ID_W-1:0]     ch,
                                                  input logic                   sat,
                                                  input logic [CNT_FIELD_W-1:0] cnt);
    logic [WORD_W-1:0] w;
    w                   = '0;
    w[CH_MSB:CH_LSB]    = ch;
    w[SAT_BIT]          = sat;
    w[CNT_FIELD_W-1:0]  = cnt;
    return w;
  endfunction

endpackage

// File: rtl/axi_hs_counter.sv
// One per-channel handshake counter with optional saturation and snapshot clear.
module axi_hs_counter
  import axi_monitor_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hs,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Count handshakes; a clear restarts at 0 or 1 so the clearing cycle's handshake is kept.
  // NOTE: non-blocking assignments so every register samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (clear) begin
      count <= CNT_W'(hs);
      sat   <= 1'b0;
    end else if (hs) begin
      if (count != CNT_MAX) begin
        count <= count + CNT_W'(1);
      end else if (SATURATE != 0) begin
        sat <= 1'b1;
      end else begin
        count <= '0;
      end
    end
  end

endmodule

// File: rtl/axi_multi_monitor.sv
// Counts AXI-Stream handshakes on NUM_CH links and periodically reports the
// snapshot as a burst of NUM_CH words on an AXI-Stream master port.
module axi_multi_monitor
  import axi_monitor_pkg::*;
#(
  parameter int          NUM_CH          = 4,
  parameter int          CNT_W           = 16,
  parameter int unsigned SAMPLE_DIV      = 200_000_000,
  parameter int          CLEAR_ON_SAMPLE = 0,
  parameter int          SATURATE        = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] mon_tvalid,
  input  logic [NUM_CH-1:0] mon_tready,
  output logic [31:0]       m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              overrun
);

  localparam int                   TMR_W   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [TMR_W-1:0]     TMR_END = TMR_W'(SAMPLE_DIV - 1);
  localparam logic [CH_ID_W-1:0]   LAST_CH = CH_ID_W'(NUM_CH - 1);

  logic [TMR_W-1:0]   timer_q;
  logic               trigger;
  logic               snapshot;
  logic               clear_cnt;
  logic [NUM_CH-1:0]  hs;
  logic [CNT_W-1:0]   cnt [NUM_CH];
  logic [NUM_CH-1:0]  sat_flag;
  logic [CNT_W-1:0]   shadow_cnt [NUM_CH];
  logic [NUM_CH-1:0]  shadow_sat;

  state_t              state_q, state_d;
  logic [CH_ID_W-1:0]  ch_q, ch_d, ch_next;
  logic                tvalid_q, tvalid_d;
  logic                tlast_q, tlast_d;
  logic [WORD_W-1:0]   tdata_q, tdata_d;
  logic                overrun_q, overrun_d;
  logic [CNT_W-1:0]    sel_cnt;
  logic                sel_sat;

  // Zero-extend a channel count into the 24-bit report field.
  function automatic logic [CNT_FIELD_W-1:0] ext_cnt(input logic [CNT_W-1:0] c);
    logic [CNT_FIELD_W-1:0] e;
    e            = '0;
    e[CNT_W-1:0] = c;
    return e;
  endfunction

  assign hs        = mon_tvalid & mon_tready;
  assign trigger   = (timer_q == TMR_END);
  assign snapshot  = trigger && (state_q == IDLE);
  assign clear_cnt = snapshot && (CLEAR_ON_SAMPLE != 0);

  // Free-running sample timer; back-pressure never stalls it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       timer_q <= '0;
    else if (trigger) timer_q <= '0;
    else              timer_q <= timer_q + TMR_W'(1);
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
    axi_hs_counter #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .hs    (hs[g]),
      .clear (clear_cnt),
      .count (cnt[g]),
      .sat   (sat_flag[g])
    );
  end

  // Capture pre-increment counts and sat flags when a snapshot is taken.
  // NOTE: the shadow array is reset because a reset must leave no stale report data behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) shadow_cnt[i] <= '0;
      shadow_sat <= '0;
    end else if (snapshot) begin
      for (int i = 0; i < NUM_CH; i++) shadow_cnt[i] <= cnt[i];
      shadow_sat <= sat_flag;
    end
  end

  // Select the shadow entry for the channel that follows the one being sent.
  always_comb begin
    ch_next = ch_q + CH_ID_W'(1);
    sel_cnt = '0;
    sel_sat = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_next == CH_ID_W'(i)) begin
        sel_cnt = shadow_cnt[i];
        sel_sat = shadow_sat[i];
      end
    end
  end

  // Report FSM next-state and registered-output logic.
  // NOTE: every signal gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    tdata_d   = tdata_q;
    overrun_d = overrun_q | (trigger && (state_q == SEND));
    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d  = SEND;
          ch_d     = '0;
          tvalid_d = 1'b1;
          tdata_d  = make_word(CH_ID_W'(0), sat_flag[0], ext_cnt(cnt[0]));
          tlast_d  = (NUM_CH == 1);
        end
      end
      SEND: begin
        // tvalid is held high for the whole of SEND, so tready alone marks acceptance.
        if (m_axis_tready) begin
          if (tlast_q) begin
            state_d  = IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
          end else begin
            ch_d    = ch_next;
            tdata_d = make_word(ch_next, sel_sat, ext_cnt(sel_cnt));
            tlast_d = (ch_next == LAST_CH);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tdata_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      tdata_q   <= tdata_d;
      overrun_q <= overrun_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign overrun       = overrun_q;

endmodule
